// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate-format codes and buffer states for the
// immediate decode pipe.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_t;

  // Encoding equals the number of buffered entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RV32/RV64 immediate extractor: format code, XLEN-wide
// immediate and an illegal flag for unsupported opcodes or shift amounts.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit SUPPORT_ZIMM = 1'b1
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_t        fmt_o,
  output logic            illegal_o
);

  localparam bit IS_RV64 = (XLEN == 64);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_itype, imm_stype, imm_btype, imm_utype, imm_jtype;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_itype = XLEN'($signed(instr_i[31:20]));
  assign imm_stype = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_btype = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                    instr_i[11:8], 1'b0}));
  assign imm_utype = XLEN'($signed({instr_i[31:12], 12'b0}));
  assign imm_jtype = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                    instr_i[30:21], 1'b0}));

  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        fmt_o = FMT_I;
        imm_o = imm_itype;
      end
      OPC_OP_IMM: begin
        fmt_o = FMT_I;
        if (!is_shift) begin
          imm_o = imm_itype;
        end else if (IS_RV64) begin
          imm_o = XLEN'(instr_i[25:20]);
        end else begin
          // shamt bit 5 does not exist on RV32; report it but keep shamt[4:0]
          imm_o     = XLEN'(instr_i[24:20]);
          illegal_o = instr_i[25];
        end
      end
      OPC_OP_IMM_32: begin
        if (IS_RV64) begin
          fmt_o = FMT_I;
          if (is_shift) begin
            imm_o     = XLEN'(instr_i[24:20]);
            illegal_o = instr_i[25];
          end else begin
            imm_o = imm_itype;
          end
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm_o = imm_stype;
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm_o = imm_btype;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm_o = imm_utype;
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm_o = imm_jtype;
      end
      OPC_OP, OPC_MISC_MEM: begin
        illegal_o = 1'b0;
      end
      OPC_OP_32: begin
        illegal_o = !IS_RV64;
      end
      OPC_SYSTEM: begin
        // CSR*I forms carry a 5-bit zero-extended immediate in the rs1 field
        if (SUPPORT_ZIMM && funct3[2] && (funct3 != 3'b100)) begin
          fmt_o = FMT_Z;
          imm_o = XLEN'(instr_i[19:15]);
        end
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_pipe.sv
// Immediate decode stage with a two-entry in-order buffer (main + skid);
// in_ready depends only on registered state.
module imm_decode_pipe
  import imm_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit SUPPORT_ZIMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [1:0]      occupancy
);

  // Entry layout: {instr, imm, fmt, illegal}
  localparam int EW = 32 + XLEN + 3 + 1;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_illegal;
  logic [EW-1:0]   dec_entry;

  buf_state_t      state_q, state_d;
  logic [EW-1:0]   main_q, main_d;
  logic [EW-1:0]   skid_q, skid_d;
  logic            push, pop;

  imm_decode_comb #(
    .XLEN         (XLEN),
    .SUPPORT_ZIMM (SUPPORT_ZIMM)
  ) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  assign dec_entry = {in_instr, dec_imm, dec_fmt, dec_illegal};

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = dec_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = dec_entry;
          end else if (push) begin
            skid_d  = dec_entry;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the head can leave
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign {out_instr, out_imm, out_fmt, out_illegal} = main_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Drives an XLEN=32 and an XLEN=64 pipe with identical stimulus and checks both
// against a queue-based reference with an arithmetic immediate decoder.
module tb_imm_decode_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_instr_a, out_imm_a;
  logic [2:0]  out_fmt_a;
  logic [1:0]  occ_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [31:0] out_instr_b;
  logic [63:0] out_imm_b;
  logic [2:0]  out_fmt_b;
  logic [1:0]  occ_b;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q[$];

  logic [6:0] opc_tab [13] = '{7'h03, 7'h0f, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h33,
                               7'h37, 7'h3b, 7'h63, 7'h67, 7'h6f, 7'h73};

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32), .SUPPORT_ZIMM(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_a), .in_instr(in_instr), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_instr(out_instr_a), .out_imm(out_imm_a),
    .out_fmt(out_fmt_a), .out_illegal(out_illegal_a), .occupancy(occ_a)
  );

  imm_decode_pipe #(.XLEN(64), .SUPPORT_ZIMM(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_b), .in_instr(in_instr), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_instr(out_instr_b), .out_imm(out_imm_b),
    .out_fmt(out_fmt_b), .out_illegal(out_illegal_b), .occupancy(occ_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint ival(input logic [31:0] w);
    longint v;
    v = w[31:20];
    if (v >= 2048) v -= 4096;
    return v;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w, input bit rv64);
    exp_t e;
    longint v;
    logic [2:0] f3;
    bit shift;
    e = '0;
    v = 0;
    f3 = w[14:12];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    case (w[6:0])
      7'h03, 7'h67: begin e.fmt = 3'd1; v = ival(w); end
      7'h13: begin
        e.fmt = 3'd1;
        if (!shift) v = ival(w);
        else if (rv64) v = w[25:20];
        else begin v = w[24:20]; e.ill = w[25]; end
      end
      7'h1b: begin
        if (!rv64) e.ill = 1'b1;
        else begin
          e.fmt = 3'd1;
          if (shift) begin v = w[24:20]; e.ill = w[25]; end
          else v = ival(w);
        end
      end
      7'h23: begin
        e.fmt = 3'd2;
        v = w[31:25] * 32 + w[11:7];
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        e.fmt = 3'd3;
        v = w[31] * 4096 + w[7] * 2048 + w[30:25] * 32 + w[11:8] * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        v = longint'(w[31:12]) * 4096;
        if (w[31]) v -= 64'sh1_0000_0000;
      end
      7'h6f: begin
        e.fmt = 3'd5;
        v = w[31] * 1048576 + w[19:12] * 4096 + w[20] * 2048 + w[30:21] * 2;
        if (v >= 1048576) v -= 2097152;
      end
      7'h33, 7'h0f: e.ill = 1'b0;
      7'h3b: e.ill = !rv64;
      7'h73: if (f3[2] && f3 != 3'd4) begin e.fmt = 3'd6; v = w[19:15]; end
      default: e.ill = 1'b1;
    endcase
    e.imm = 64'(v);
    return e;
  endfunction

  task automatic check_outputs();
    int n;
    exp_t e32, e64;
    n = q.size();
    chk("occ32", 64'(occ_a), 64'(n));
    chk("occ64", 64'(occ_b), 64'(n));
    chk("ovalid32", 64'(out_valid_a), 64'(n != 0));
    chk("ovalid64", 64'(out_valid_b), 64'(n != 0));
    chk("irdy32", 64'(in_ready_a), 64'(n < 2));
    chk("irdy64", 64'(in_ready_b), 64'(n < 2));
    if (n > 0) begin
      e32 = ref_decode(q[0], 1'b0);
      e64 = ref_decode(q[0], 1'b1);
      chk("instr32", 64'(out_instr_a), 64'(q[0]));
      chk("instr64", 64'(out_instr_b), 64'(q[0]));
      chk("imm32", 64'(out_imm_a), 64'(e32.imm[31:0]));
      chk("imm64", out_imm_b, e64.imm);
      chk("fmt32", 64'(out_fmt_a), 64'(e32.fmt));
      chk("fmt64", 64'(out_fmt_b), 64'(e64.fmt));
      chk("ill32", 64'(out_illegal_a), 64'(e32.ill));
      chk("ill64", 64'(out_illegal_b), 64'(e64.ill));
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
    bit push, pop;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    push = v && (q.size() < 2) && !fl;
    pop  = (q.size() > 0) && rdy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ins);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 15);
    if (k < 13) w[6:0] = opc_tab[k];
    return w;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_occ"}, 64'({occ_a, occ_b}), 64'(0));
    chk({tag, "_ovalid"}, 64'({out_valid_a, out_valid_b}), 64'(0));
    chk({tag, "_irdy"}, 64'({in_ready_a, in_ready_b}), 64'(2'b11));
    chk({tag, "_instr"}, {out_instr_a, out_instr_b}, 64'(0));
    chk({tag, "_imm"}, out_imm_b | 64'(out_imm_a), 64'(0));
    chk({tag, "_fmt_ill"}, 64'({out_fmt_a, out_illegal_a, out_fmt_b, out_illegal_b}), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed decode vectors, full throughput
    step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    step(1'b1, 32'hFE112E23, 1'b1, 1'b0);
    step(1'b1, 32'h800002B7, 1'b1, 1'b0);
    step(1'b1, 32'h02009093, 1'b1, 1'b0);
    step(1'b1, 32'h0002D073, 1'b1, 1'b0);
    step(1'b1, 32'h00000013 | 32'h0200101B, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // backpressure: A,B fill, C refused until space frees
    step(1'b1, 32'h00100093, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 1'b0, 1'b0);
    #1;
    chk("full_irdy", 64'(in_ready_a), 64'(0));
    chk("full_occ", 64'(occ_b), 64'(2));
    step(1'b1, 32'h00300193, 1'b1, 1'b0);
    step(1'b1, 32'h00300193, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // flush when full, and flush racing an accepted input
    step(1'b1, 32'h00400213, 1'b0, 1'b0);
    step(1'b1, 32'h00500293, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 1'b0, 1'b1);
    #1;
    chk("flush_occ", 64'(occ_a), 64'(0));
    chk("flush_ovalid", 64'(out_valid_b), 64'(0));
    step(1'b1, 32'h00700393, 1'b0, 1'b0);
    step(1'b1, 32'h00800413, 1'b1, 1'b1);
    #1;
    chk("flush1_occ", 64'(occ_b), 64'(0));
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset with one entry buffered
    step(1'b1, 32'h00900493, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h00A00513, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
